// File: rtl/mult_sequencer.sv
// mult_sequencer: control sequencer for the signed add-shift multiplier.
// It steps the X/A/B datapath through WIDTH add/shift iterations and uses a
// subtract on the last step, so the product has two's-complement meaning.
// It also handles ClearA_LoadB requests, which are edge-detected.
//
// Ports:
//   Clk      - system clock, rising edge
//   Reset    - synchronous, active-high
//   Start    - level run request (synchronized), acted on only in IDLE
//   LoadB    - ClearA_LoadB request (synchronized), rising edge detected here
//   M        - current B[0] from the datapath
//   Ready    - high in IDLE
//   Busy     - high in CLRA, ADD and SHIFT
//   Done     - one-cycle pulse on the first HOLD cycle
//   Clr_Ld   - clear X and A, load B from Din
//   ClrA     - clear X and A, keep B
//   Add      - load adder result into X:A
//   Fn       - adder function (0 = A+S, 1 = A-S)
//   Shift_En - arithmetic right shift X->A->B
//   Count    - current iteration index
module mult_sequencer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       Start,
  input  logic                       LoadB,
  input  logic                       M,
  output logic                       Ready,
  output logic                       Busy,
  output logic                       Done,
  output logic                       Clr_Ld,
  output logic                       ClrA,
  output logic                       Add,
  output logic                       Fn,
  output logic                       Shift_En,
  output logic [$clog2(WIDTH)-1:0]   Count
);

  localparam int unsigned CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOADB,
    S_CLRA,
    S_ADD,
    S_SHIFT,
    S_HOLD
  } state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic          first_hold;
  logic          loadb_q;
  logic          loadb_rise;

  // LoadB rising edge; loadb_q resets high so a level held through reset is ignored
  assign loadb_rise = LoadB & ~loadb_q;

  // State, iteration counter, Done flag and edge-detect register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= S_IDLE;
      count      <= '0;
      first_hold <= 1'b0;
      loadb_q    <= 1'b1;
    end else begin
      loadb_q    <= LoadB;
      first_hold <= 1'b0;
      case (state)
        S_IDLE: begin
          if (loadb_rise) begin
            state <= S_LOADB;
          end else if (Start) begin
            state <= S_CLRA;
            count <= '0;
          end
        end
        S_LOADB: state <= S_IDLE;
        S_CLRA:  state <= S_ADD;
        S_ADD:   state <= S_SHIFT;
        S_SHIFT: begin
          if (count == LAST) begin
            state      <= S_HOLD;
            count      <= '0;
            first_hold <= 1'b1;
          end else begin
            state <= S_ADD;
            count <= count + CW'(1);
          end
        end
        S_HOLD: begin
          // Wait for Start to drop so one Start assertion yields one multiply
          if (!Start) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Output decode from state, count, M and the first-HOLD flag
  always_comb begin
    Ready    = 1'b0;
    Busy     = 1'b0;
    Done     = 1'b0;
    Clr_Ld   = 1'b0;
    ClrA     = 1'b0;
    Add      = 1'b0;
    Fn       = 1'b0;
    Shift_En = 1'b0;
    case (state)
      S_IDLE:  Ready = 1'b1;
      S_LOADB: Clr_Ld = 1'b1;
      S_CLRA: begin
        Busy = 1'b1;
        ClrA = 1'b1;
      end
      S_ADD: begin
        Busy = 1'b1;
        Add  = M;
        // Last partial product carries negative weight in two's complement
        Fn   = (count == LAST);
      end
      S_SHIFT: begin
        Busy     = 1'b1;
        Shift_En = 1'b1;
      end
      S_HOLD:  Done = first_hold;
      default: ;
    endcase
  end

  assign Count = count;

endmodule

// File: tb/tb_mult_sequencer.sv
module tb_mult_sequencer;

  localparam int unsigned WIDTH = 8;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Start;
  logic       LoadB;
  logic       M;
  logic       Ready, Busy, Done, Clr_Ld, ClrA, Add, Fn, Shift_En;
  logic [2:0] Count;

  // Behavioral datapath
  logic [7:0] Din;
  logic       X;
  logic [7:0] A, B;
  logic [8:0] sum;

  int n_vec = 0;
  int n_err = 0;
  int n_done;
  int n_busy;
  logic [15:0] exp_q[$];
  logic [7:0]  b_loaded;

  wire [10:0] ctl = {Ready, Busy, Done, Clr_Ld, ClrA, Add, Fn, Shift_En, Count};

  localparam logic [10:0] CTL_IDLE = 11'b100_0000_0000;

  mult_sequencer #(.WIDTH(WIDTH)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Start    (Start),
    .LoadB    (LoadB),
    .M        (M),
    .Ready    (Ready),
    .Busy     (Busy),
    .Done     (Done),
    .Clr_Ld   (Clr_Ld),
    .ClrA     (ClrA),
    .Add      (Add),
    .Fn       (Fn),
    .Shift_En (Shift_En),
    .Count    (Count)
  );

  always #5 Clk = ~Clk;

  assign M   = B[0];
  assign sum = Fn ? ({A[7], A} - {Din[7], Din}) : ({A[7], A} + {Din[7], Din});

  always @(posedge Clk) begin
    if (Clr_Ld) begin
      X <= 1'b0; A <= 8'h00; B <= Din;
    end else if (ClrA) begin
      X <= 1'b0; A <= 8'h00;
    end else if (Add) begin
      {X, A} <= sum;
    end else if (Shift_En) begin
      A <= {X, A[7:1]};
      B <= {A[0], B[7:1]};
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Expected control vector for cycle k after Start was sampled at edge t0,
  // with Start held high for 'hold' edges (t0 .. t0+hold-1).
  function automatic logic [10:0] exp_ctl(input int k, input int hold, input logic [7:0] bv);
    logic r, b, d, cl, ca, ad, fn, sh;
    logic [2:0] c;
    int idle_at;
    int i;
    {r, b, d, cl, ca, ad, fn, sh} = '0;
    c = 3'd0;
    idle_at = (hold > 18) ? hold : 18;
    if (k >= idle_at) begin
      r = 1'b1;
    end else if (k == 0) begin
      b = 1'b1; ca = 1'b1;
    end else if (k <= 16) begin
      b = 1'b1;
      if (k % 2 == 1) begin
        i  = (k - 1) / 2;
        ad = bv[i];
        fn = (i == 7);
      end else begin
        i  = (k - 2) / 2;
        sh = 1'b1;
      end
      c = 3'(i);
    end else begin
      d = (k == 17);
    end
    return {r, b, d, cl, ca, ad, fn, sh, c};
  endfunction

  function automatic logic [15:0] sprod(input logic [7:0] s, input logic [7:0] bv);
    int sp, bp;
    sp = $signed(s);
    bp = $signed(bv);
    return 16'(sp * bp);
  endfunction

  task automatic sample_done();
    logic [15:0] e;
    if (Done) begin
      n_done++;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
      check("product", {16'h0, A, B}, {16'h0, e});
    end
  endtask

  task automatic load_b(input logic [7:0] v, input int hi);
    int n_ld = 0;
    int n_b  = 0;
    Din = v; LoadB = 1'b1;
    for (int k = 0; k < hi + 3; k++) begin
      step();
      n_ld += int'(Clr_Ld);
      n_b  += int'(Busy);
      if (k == hi - 1) LoadB = 1'b0;
    end
    b_loaded = v;
    check("clr_ld_pulses", n_ld, 1);
    check("load_no_run", n_b, 0);
    check("load_idle", 32'(ctl), 32'(CTL_IDLE));
  endtask

  task automatic run_mult(input logic [7:0] s, input int hold, input int lb_at);
    int last;
    Din = s;
    exp_q.push_back(sprod(s, b_loaded));
    n_done = 0; n_busy = 0;
    Start = 1'b1;
    step();
    last = (hold > 18) ? hold : 18;
    for (int k = 0; k <= last; k++) begin
      check($sformatf("ctl[%0d]", k), 32'(ctl), 32'(exp_ctl(k, hold, b_loaded)));
      n_busy += int'(Busy);
      sample_done();
      Start = (k + 1 < hold);
      LoadB = (k == lb_at);
      step();
    end
    LoadB = 1'b0;
    check("done_count", n_done, 1);
    check("busy_cycles", n_busy, 17);
    check("queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n_ld;
    Reset = 1'b1; Start = 1'b0; LoadB = 1'b1; Din = 8'h00;
    b_loaded = 8'h00;

    // Reset for 2 cycles with LoadB held high: no load afterwards
    step(); step();
    check("reset_ctl", 32'(ctl), 32'(CTL_IDLE));
    Reset = 1'b0;
    n_ld = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      n_ld += int'(Clr_Ld);
    end
    check("post_reset_ctl", 32'(ctl), 32'(CTL_IDLE));
    check("loadb_thru_reset", n_ld, 0);
    LoadB = 1'b0;
    step();

    // LoadB held 5 cycles: single Clr_Ld, no run
    load_b(8'h07, 5);
    run_mult(8'hFD, 1, -1);          // -3 * 7 = -21

    load_b(8'hFD, 1);
    run_mult(8'hFD, 1, -1);          // -3 * -3 = 9

    // Start held 30 cycles; LoadB pulse mid-run must be ignored
    load_b(8'h85, 1);
    run_mult(8'h7F, 30, 5);

    // Reset mid-run at t0+8
    Din = 8'h33; n_done = 0;
    Start = 1'b1;
    step();
    Start = 1'b0;
    for (int k = 1; k < 8; k++) step();
    Reset = 1'b1;
    step();
    check("abort_ctl", 32'(ctl), 32'(CTL_IDLE));
    Reset = 1'b0;
    for (int k = 0; k < 25; k++) begin
      step();
      n_done += int'(Done);
    end
    check("abort_no_done", n_done, 0);

    // Start and LoadB edge together: load first, then IDLE, then run on fresh B
    Din = 8'h12; LoadB = 1'b1; Start = 1'b1;
    step();
    check("combo_load", 32'(ctl), 32'(11'b000_1000_0000));
    LoadB = 1'b0;
    step();
    check("combo_idle", 32'(ctl), 32'(CTL_IDLE));
    b_loaded = 8'h12;
    exp_q.push_back(sprod(8'h12, 8'h12));
    step();
    check("combo_clra", 32'(ctl), 32'(11'b010_0100_0000));
    Start = 1'b0;
    n_done = 0;
    for (int k = 0; k < 25; k++) begin
      step();
      sample_done();
    end
    check("combo_done", n_done, 1);
    check("combo_queue", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
